// File: rtl/nios2_jtag_debug_host_shifter.sv
// nios2_jtag_debug_host_shifter
// Host-side initiator for the Nios II JTAG debug module's virtual-JTAG port.
// Takes one command (IR code + DR word) per valid/ready handshake. It then walks
// the target through UIR, CDR, SDR, UDR and RTI while generating TCK and TDI.
// TDO is captured into a DR_WIDTH-bit response word that is held until the
// response handshake.
//
// Optional feature: define NIOS2_JTAG_HOST_SKIP_IR_EN to add the cmd_skip_ir
// port. A command with cmd_skip_ir=1 bypasses UIR, and vji_ir_in keeps its
// previous value.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ir, cmd_dr (LSB shifted first)
//   cmd_skip_ir           skip the IR update (optional feature only)
//   rsp_valid/rsp_ready   response handshake; rsp_dr bit i = TDO of shift period i
//   busy                  high whenever the machine is not idle
//   vji_tck/tdi/tdo       generated TCK, serial data out, serial data in
//   vji_ir_in             IR value presented to the target
//   vji_uir/cdr/sdr/udr/rti  per-state virtual strobes
module nios2_jtag_debug_host_shifter #(
  parameter int unsigned DR_WIDTH   = 38,
  parameter int unsigned IR_WIDTH   = 2,
  parameter int unsigned TCK_DIV    = 2,
  parameter int unsigned RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
`ifdef NIOS2_JTAG_HOST_SKIP_IR_EN
  input  logic                cmd_skip_ir,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned PERIOD   = 2 * TCK_DIV;
  localparam int unsigned PH_W     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned CNT_MAX  = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PH_LAST_I  = (PERIOD == 0) ? 0 : PERIOD - 1;
  localparam int unsigned RTI_LAST_I = (RTI_CYCLES == 0) ? 0 : RTI_CYCLES - 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PH_LAST_I);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV);
  localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(DR_WIDTH - 1);
  localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_LAST_I);

  // A zero half-period would never toggle TCK.
  if (TCK_DIV == 0) begin : g_bad_tck_div
    $error("nios2_jtag_debug_host_shifter: TCK_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_DONE
  } state_t;

  state_t               state_q, state_nxt;
  logic [PH_W-1:0]      phase_q, phase_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [DR_WIDTH-1:0]  sh_q, sh_nxt;
  logic [DR_WIDTH-1:0]  cap_q, cap_nxt;
  logic [DR_WIDTH-1:0]  rsp_dr_nxt;
  logic [IR_WIDTH-1:0]  ir_nxt;
  logic                 period_end;
  logic                 tck_state_nxt;
  logic                 skip_ir;

`ifdef NIOS2_JTAG_HOST_SKIP_IR_EN
  assign skip_ir = cmd_skip_ir;
`else
  assign skip_ir = 1'b0;
`endif

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_nxt  = state_q;
    phase_nxt  = '0;
    cnt_nxt    = cnt_q;
    sh_nxt     = sh_q;
    cap_nxt    = cap_q;
    rsp_dr_nxt = rsp_dr;
    ir_nxt     = vji_ir_in;
    period_end = (phase_q == PH_LAST);

    // Phase advances in every TCK-generating state and wraps each period.
    if (state_q != S_IDLE && state_q != S_DONE && !period_end) begin
      phase_nxt = phase_q + PH_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          sh_nxt  = cmd_dr;
          cap_nxt = '0;
          cnt_nxt = '0;
          if (skip_ir) begin
            state_nxt = S_CDR;
          end else begin
            state_nxt = S_UIR;
            ir_nxt    = cmd_ir;
          end
        end
      end
      S_UIR: begin
        if (period_end) state_nxt = S_CDR;
      end
      S_CDR: begin
        if (period_end) begin
          state_nxt = S_SDR;
          cnt_nxt   = '0;
        end
      end
      S_SDR: begin
        // First high cycle of the period: TCK has just risen.
        if (phase_q == PH_RISE) begin
          cap_nxt = {vji_tdo, cap_q[DR_WIDTH-1:1]};
        end
        if (period_end) begin
          if (cnt_q == DR_LAST) begin
            state_nxt = S_UDR;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
            sh_nxt  = sh_q >> 1;
          end
        end
      end
      S_UDR: begin
        if (period_end) begin
          cnt_nxt = '0;
          if (RTI_CYCLES == 0) begin
            state_nxt  = S_DONE;
            rsp_dr_nxt = cap_q;
          end else begin
            state_nxt = S_RTI;
          end
        end
      end
      S_RTI: begin
        if (period_end) begin
          if (cnt_q == RTI_LAST) begin
            state_nxt  = S_DONE;
            rsp_dr_nxt = cap_q;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    tck_state_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      cap_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      busy      <= 1'b0;
      vji_tck   <= 1'b0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      phase_q   <= phase_nxt;
      cnt_q     <= cnt_nxt;
      sh_q      <= sh_nxt;
      cap_q     <= cap_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_DONE);
      rsp_dr    <= rsp_dr_nxt;
      busy      <= (state_nxt != S_IDLE);
      vji_tck   <= tck_state_nxt && (phase_nxt >= PH_RISE);
      vji_tdi   <= (state_nxt == S_SDR) ? sh_nxt[0] : 1'b0;
      vji_ir_in <= ir_nxt;
      vji_uir   <= (state_nxt == S_UIR);
      vji_cdr   <= (state_nxt == S_CDR);
      vji_sdr   <= (state_nxt == S_SDR);
      vji_udr   <= (state_nxt == S_UDR);
      vji_rti   <= (state_nxt == S_RTI);
    end
  end

endmodule

// File: doc/nios2_jtag_debug_host_shifter.md
Name: nios2_jtag_debug_host_shifter

Overview:
- Host-side initiator for the Nios II JTAG debug module's virtual-JTAG port.
- Takes one command (IR code plus 38-bit data word) per handshake and generates the UIR, CDR, SDR, UDR and RTI sequence and the TCK/TDI stream that the debug module's TCK-domain logic expects.
- Captures TDO into a 38-bit response word.
- Used in simulation benches and on-chip self-test to drive the debug module without a physical JTAG cable.

Parameters:
- DR_WIDTH, 38: data-register shift length in bits.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: TCK half-period in clk cycles; must be ≥1.
- RTI_CYCLES, 2: TCK periods spent in run-test-idle after each update.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_ir  in  IR_WIDTH  IR code to load.
- cmd_dr  in  DR_WIDTH  data shifted out LSB first.
- cmd_skip_ir  in  1  present only with the optional feature.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_dr  out  DR_WIDTH  captured TDO word; bit i is the bit sampled in shift period i.
- busy  out  1  high in any state except IDLE.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to target.
- vji_tdo  in  1  serial data from target.
- vji_ir_in  out  IR_WIDTH  IR value presented to target.
- vji_uir  out  1  virtual update-IR strobe.
- vji_cdr  out  1  virtual capture-DR strobe.
- vji_sdr  out  1  virtual shift-DR strobe.
- vji_udr  out  1  virtual update-DR strobe.
- vji_rti  out  1  run-test-idle strobe.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - cmd_ready=0 during reset, then 1 in IDLE.
  - rsp_valid=0, rsp_dr=0, busy=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - All virtual strobes 0.
- State machine: IDLE → UIR → CDR → SDR → UDR → RTI → DONE → IDLE.
- TCK period timing (all states except IDLE and DONE):
  - One period = 2*TCK_DIV clk cycles.
  - vji_tck is 0 for the first TCK_DIV cycles and 1 for the second TCK_DIV cycles.
  - vji_tck is held 0 in IDLE and DONE.
- Strobes: each state's strobe is high for every clk cycle of that state; at most one strobe is high at a time.
- State durations:
  - UIR, CDR, UDR: one period each.
  - SDR: DR_WIDTH periods.
  - RTI: RTI_CYCLES periods; if RTI_CYCLES=0, UDR → DONE directly.
- Command acceptance:
  - cmd_ready=1 only in IDLE.
  - On acceptance, cmd_ir and cmd_dr are latched and the machine enters UIR on the next cycle.
- vji_ir_in is driven from the latched IR starting in UIR and holds that value after completion until the next UIR.
- SDR shifting:
  - vji_tdi presents bit i of the latched data for all of shift period i; it changes only on the clk cycle where vji_tck falls (or at SDR entry).
  - vji_tdo is sampled on the clk cycle where vji_tck goes 0→1 and stored in rsp_dr bit i.
  - vji_tdi returns to 0 outside SDR.
- Latency: the command handshake occurs at cycle 0; UIR starts at cycle 1. With defaults, rsp_valid rises at cycle 1+(3+38+2)*4 = 173.
- Response:
  - In DONE, rsp_valid=1 and rsp_dr is stable until the rsp_ready handshake, then the machine returns to IDLE.
  - A new command is not accepted while a response is pending.
  - If cmd_valid is high in the same cycle as the response handshake, the command is accepted in the following cycle, in IDLE.
- Reset mid-operation:
  - The machine returns to IDLE on the next cycle with all outputs at reset values.
  - The partial response is discarded; no rsp_valid is asserted.
- TCK_DIV=0 is illegal; a simulation-only assertion fires at time 0.

Optional Feature:
- Macro: NIOS2_JTAG_HOST_SKIP_IR_EN.
- When defined:
  - The cmd_skip_ir port exists and is latched with the command.
  - If cmd_skip_ir=1, UIR is skipped (IDLE → CDR), vji_ir_in keeps its previous value, and latency shrinks by one TCK period.
- When undefined: the port is absent and UIR is always executed.

Test Plan:
- Reset then idle → cmd_ready=1, busy=0, vji_tck=0, all strobes 0, rsp_valid=0.
- Basic shift, TCK_DIV=2: cmd_ir=2'b01, cmd_dr=38'h15_5555_5555. Bench TDO model loads 38'h2A_AAAA_AAAA on CDR and shifts it out LSB first.
  - vji_ir_in=01 from UIR onward.
  - 38 TDI bits seen LSB first, matching cmd_dr.
  - rsp_valid at cycle 173.
  - rsp_dr=38'h2A_AAAA_AAAA.
- Strobe ordering: check uir(4 clk), cdr(4), sdr(152), udr(4), rti(8) with no overlap, and exactly 38 vji_tck rising edges while vji_sdr=1.
- Backpressure: hold rsp_ready=0 for 20 cycles with cmd_valid=1.
  - rsp_valid and rsp_dr stay stable; cmd_ready=0 throughout.
  - After the rsp_ready pulse, cmd_ready=1 on the next cycle.
- Reset asserted during SDR shift bit 10 → next cycle all outputs at reset values, state IDLE, no rsp_valid.
  - A following command completes normally with the correct rsp_dr.
- With NIOS2_JTAG_HOST_SKIP_IR_EN: first command cmd_ir=2'b10, then cmd_skip_ir=1 with cmd_ir=2'b11.
  - Second command has no vji_uir pulse and vji_ir_in stays 10.
  - rsp_valid arrives at cycle 169 after the second handshake.
